mem_responder_16b: RTL and testbench
====================================

Name: mem_responder_16B

Overview:
- Single-ported, line-granular memory responder serving as the memory end of the 16B memory interface driven by the blocking caches.
- Accepts one mem_req_16B_t at a time over val/rdy and returns one mem_resp_16B_t after a programmable fixed latency.
- Used as the backing store in cache unit tests and in the single-core memory system.
- Non-pipelined: at most one transaction in flight.

Parameters:
- p_num_lines, 256: number of 128-bit lines stored; power of two, minimum 2.
- p_latency, 2: extra wait cycles between request acceptance and response valid; range 0–15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memreq_msg  in  175  mem_req_16B_t fields:
  - [174:172] type
  - [171:164] opaque
  - [163:132] addr
  - [131:128] len
  - [127:0] data
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.
- memresp_msg  out  145  mem_resp_16B_t fields:
  - [144:142] type
  - [141:134] opaque
  - [133:132] test
  - [131:128] len
  - [127:0] data
- num_reqs  out  32  count of accepted requests since reset.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all of the following hold:
  - state = IDLE.
  - memreq_rdy = 0.
  - memresp_val = 0.
  - num_reqs = 0.
  - latency counter = 0.
  - memresp_msg = 0.
- Line storage is not reset. A read of a never-written line returns X in simulation.
- Line index = addr[3+log2(p_num_lines):4]. Higher address bits are ignored, so addresses wrap modulo p_num_lines*16. addr[3:0] is ignored.
- len is ignored for storage: every access is a full 16B line. The response len field is 0.
- Type codes:
  - READ = 0: response data = stored line.
  - WRITE = 1: all 16 bytes of the line are written; response data = 0.
  - INIT = 2: same as WRITE, except the response type echoes 2.
  - Any other type: no storage change; response data = 0; response test field = 2'b11 (error flag).
  - For READ, WRITE and INIT, the response test field = 2'b00.
- The response echoes the request's type and opaque fields.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: memreq_rdy = 1. On memreq_val & memreq_rdy:
    - Latch type, opaque and line index.
    - A WRITE/INIT commits to storage at this clock edge.
    - A READ captures the line into the response data register at this edge. This is the pre-write value; no write can be in flight.
    - Increment num_reqs (wraps at 2^32).
    - Load the latency counter with p_latency.
    - Go to WAIT if p_latency > 0, otherwise go to RESP.
  - WAIT: memreq_rdy = 0, memresp_val = 0. The counter decrements each cycle. When the counter reaches 1, the next state is RESP.
  - RESP: memresp_val = 1 and memresp_msg is stable. memresp_msg must not change while val=1 and rdy=0. On memresp_rdy, go to IDLE.
- Latency: request accepted at edge N → memresp_val high from cycle N+1+p_latency.
- Throughput: at most one transaction per 2+p_latency cycles when memresp_rdy is held high.
- memreq_rdy depends only on state and never combinationally on memresp_rdy or memreq_val.
- memresp_val depends only on state.
- memreq_val asserted during WAIT or RESP is not accepted; the requester must hold it.
- Reset mid-transaction: the in-flight response is dropped. A WRITE already committed at acceptance remains in storage.
- memresp_rdy asserted outside RESP has no effect.
- The first cycle after reset deassertion is IDLE with memreq_rdy = 1.

Test Plan:
- Write then read, p_latency=0, memresp_rdy held 1:
  - WRITE addr 0x00001000, data 0x0123_4567_89ab_cdef_0011_2233_4455_6677, opaque 0x05 → response type 1, opaque 0x05, data 0, one cycle after accept.
  - Then READ addr 0x00001004, opaque 0x06 → data = the written line, test 2'b00.
  - num_reqs = 2.
- Latency, p_latency=3: READ accepted at edge N → memresp_val first high at cycle N+4.
  - memreq_rdy = 0 during cycles N+1 through N+4.
  - memreq_rdy returns to 1 the cycle after the response handshake.
- Backpressure: hold memresp_rdy=0 for 5 cycles during RESP → memresp_val stays 1 and memresp_msg is unchanged every cycle.
  - A new memreq_val held high during this window is not accepted until after the response fires.
- Wrap-around, p_num_lines=256:
  - WRITE to addr 0x00000010 with data 0xAAAA…AA.
  - READ addr 0x00001010 (same index 1) → returns 0xAAAA…AA.
- Illegal type: request type 5, opaque 0x7F → response type 5, opaque 0x7F, test 2'b11, data 0; storage is unchanged, verified by a subsequent READ.
- Mid-transaction reset, p_latency=4:
  - WRITE to addr 0x20 with data 0x55…55; assert reset for 1 cycle during WAIT.
  - Check: memresp_val = 0, num_reqs = 0, memreq_rdy = 1 after release.
  - A subsequent READ of 0x20 returns 0x55…55.

Source files
------------

// File: rtl/mem_responder_16b_if.sv
// Request/response bundle between a blocking cache (master) and the
// line-granular memory responder (slave).
interface mem_responder_16b_if;

    // Request channel: {type[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
    logic         memreq_val;
    logic         memreq_rdy;
    logic [174:0] memreq_msg;

    // Response channel: {type[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
    logic         memresp_val;
    logic         memresp_rdy;
    logic [144:0] memresp_msg;

    // Requester side (cache / testbench)
    modport master (
        output memreq_val,
        input  memreq_rdy,
        output memreq_msg,
        input  memresp_val,
        output memresp_rdy,
        input  memresp_msg
    );

    // Memory side
    modport slave (
        input  memreq_val,
        output memreq_rdy,
        input  memreq_msg,
        output memresp_val,
        input  memresp_rdy,
        output memresp_msg
    );

endinterface

// File: rtl/mem_responder_16b.sv
// Single-ported 16-byte-line memory responder. Accepts one request at a
// time, commits writes / captures reads at acceptance, then presents the
// response after p_latency wait cycles and holds it until taken.
module mem_responder_16b #(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_16b_if.slave   bus,
    output logic [31:0]          num_reqs
);

    localparam int         IDX_W   = $clog2(p_num_lines);
    localparam logic [3:0] LAT     = 4'(p_latency);

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;
    localparam logic [2:0] T_INIT  = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Request field decode
    logic [2:0]       req_type;
    logic [7:0]       req_opaque;
    logic [31:0]      req_addr;
    logic [127:0]     req_data;
    logic [IDX_W-1:0] req_idx;
    logic             req_is_rd;
    logic             req_is_wr;
    logic             req_fire;

    assign req_type   = bus.memreq_msg[174:172];
    assign req_opaque = bus.memreq_msg[171:164];
    assign req_addr   = bus.memreq_msg[163:132];
    assign req_data   = bus.memreq_msg[127:0];
    assign req_idx    = req_addr[4 +: IDX_W];
    assign req_is_rd  = (req_type == T_READ);
    assign req_is_wr  = (req_type == T_WRITE) || (req_type == T_INIT);

    // len and the byte-offset / high address bits never affect storage
    logic unused_req_bits;
    assign unused_req_bits = ^{bus.memreq_msg[131:128], req_addr};

    // Registered state
    state_t       state_q;
    logic [3:0]   cnt_q;
    logic         resp_val_q;
    logic [31:0]  num_reqs_q;
    logic [2:0]   type_q;
    logic [7:0]   opaque_q;
    logic [1:0]   test_q;
    logic         rd_sel_q;
    logic [127:0] rd_line_q;

    // Line storage: no reset so it maps onto block RAM
    logic [127:0] mem_q [p_num_lines];

    // Ready is a pure state decode, held low while reset is asserted
    assign bus.memreq_rdy = (state_q == S_IDLE) && !reset;
    assign req_fire       = bus.memreq_rdy && bus.memreq_val;

    // Storage port: write commits and read capture both happen at acceptance
    always_ff @(posedge clk) begin
        if (req_fire && req_is_wr) begin
            mem_q[req_idx] <= req_data;
        end
        if (req_fire && req_is_rd) begin
            rd_line_q <= mem_q[req_idx];
        end
    end

    // Transaction FSM with latency counter and registered response fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            resp_val_q <= 1'b0;
            num_reqs_q <= 32'd0;
            type_q     <= 3'd0;
            opaque_q   <= 8'd0;
            test_q     <= 2'b00;
            rd_sel_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        type_q     <= req_type;
                        opaque_q   <= req_opaque;
                        test_q     <= (req_is_rd || req_is_wr) ? 2'b00 : 2'b11;
                        rd_sel_q   <= req_is_rd;
                        num_reqs_q <= num_reqs_q + 32'd1;
                        cnt_q      <= LAT;
                        if (LAT != 4'd0) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q    <= S_RESP;
                            resp_val_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q      <= 4'd0;
                        state_q    <= S_RESP;
                        resp_val_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.memresp_rdy) begin
                        state_q    <= S_IDLE;
                        resp_val_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    resp_val_q <= 1'b0;
                end
            endcase
        end
    end

    // Response assembly: only reads return line data; len is always 0.
    // rd_line_q only changes on acceptance, so the message is stable in RESP.
    assign bus.memresp_val = resp_val_q;
    assign bus.memresp_msg = {type_q, opaque_q, test_q, 4'd0,
                              rd_sel_q ? rd_line_q : 128'd0};
    assign num_reqs        = num_reqs_q;

endmodule

// File: tb/tb_mem_responder_16b.sv
// Scoreboard bench for mem_responder_16b: a driver issues requests and pushes
// expected responses computed from a line-array model; a monitor pops and
// compares on each response handshake and checks latency, handshake rules
// and backpressure stability.
module tb_mem_responder_16b;

    localparam int LAT = 3;
    localparam int NL  = 256;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] num_reqs;

    mem_responder_16b_if bus();

    mem_responder_16b #(
        .p_num_lines (NL),
        .p_latency   (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .num_reqs (num_reqs)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [144:0] msg;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp   = 0;
    int           n_err   = 0;
    int           n_acc   = 0;
    int           n_resp  = 0;
    int           cyc     = 0;
    int           exp_num = 0;
    logic [127:0] mem_m [NL];
    bit           rnd_rdy  = 1'b0;
    logic         rdy_hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [144:0] act, input logic [144:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [144:0] mk(input logic [2:0] t, input logic [7:0] op,
                                        input logic [1:0] tst, input logic [127:0] d);
        return {t, op, tst, 4'd0, d};
    endfunction

    // Issue one request, wait for acceptance, update the model and scoreboard
    task automatic send(input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] addr, input logic [127:0] d);
        int           w = 0;
        int           idx;
        logic [127:0] dexp;
        logic [1:0]   texp;
        @(posedge clk); #1;
        bus.memreq_val = 1'b1;
        bus.memreq_msg = {t, op, addr, 4'(w), d};
        forever begin
            @(negedge clk);
            if (bus.memreq_rdy) break;
            w++;
            if (w > 300) begin
                n_cmp++; n_err++;
                $display("FAIL req_accept_timeout: got no accept required accept");
                bus.memreq_val = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        idx  = int'(addr[11:4]);
        texp = 2'b00;
        dexp = 128'd0;
        if (t == 3'd0) begin
            dexp = mem_m[idx];
        end else if (t == 3'd1 || t == 3'd2) begin
            mem_m[idx] = d;
        end else begin
            texp = 2'b11;
        end
        sb.push_back('{msg: mk(t, op, texp, dexp), acc: cyc});
        n_acc++;
        exp_num++;
        $display("req  type=%0d op=%02h addr=%08h data=%032h", t, op, addr, d);
        bus.memreq_val = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (n_acc != n_resp && w < 500) begin
            @(posedge clk);
            w++;
        end
        n_cmp++;
        if (n_acc != n_resp) begin
            n_err++;
            $display("FAIL drain: got %0d responses required %0d", n_resp, n_acc);
        end
    endtask

    // Response-ready driver
    initial begin
        bus.memresp_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.memresp_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_hold;
        end
    end

    // Monitor: handshake invariants, latency, stability and scoreboard compare
    initial begin
        logic         pv = 1'b0;
        logic         ph = 1'b0;
        logic [144:0] pm = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                ph = 1'b0;
                continue;
            end
            if (n_acc == n_resp) begin
                chk("req_rdy_idle", 145'(bus.memreq_rdy), 145'd1);
                chk("resp_val_idle", 145'(bus.memresp_val), 145'd0);
            end else begin
                chk("req_rdy_busy", 145'(bus.memreq_rdy), 145'd0);
            end
            if (ph) begin
                chk("hold_val", 145'(bus.memresp_val), 145'd1);
                chk("hold_msg", bus.memresp_msg, pm);
            end
            if (bus.memresp_val && !pv) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_resp: got %0h required none", bus.memresp_msg);
                end else begin
                    chk("latency", 145'(cyc - sb[0].acc), 145'(LAT));
                end
            end
            if (bus.memresp_val && bus.memresp_rdy && sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_msg", bus.memresp_msg, e.msg);
                $display("resp msg=%037h", bus.memresp_msg);
                n_resp++;
            end
            ph = bus.memresp_val && !bus.memresp_rdy;
            pm = bus.memresp_msg;
            pv = bus.memresp_val;
        end
    end

    // Stimulus
    initial begin
        logic [31:0]  a;
        logic [127:0] d;
        int           r;
        int           tsel;
        bus.memreq_val = 1'b0;
        bus.memreq_msg = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 145'(bus.memreq_rdy), 145'd0);
        chk("rst_resp_val", 145'(bus.memresp_val), 145'd0);
        chk("rst_num_reqs", 145'(num_reqs), 145'd0);
        chk("rst_resp_msg", bus.memresp_msg, 145'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 145'(bus.memreq_rdy), 145'd1);

        // Write then read back through an ignored offset
        send(3'd1, 8'h05, 32'h0000_1000, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        send(3'd0, 8'h06, 32'h0000_1004, 128'd0);
        drain();
        chk("num_reqs_2", 145'(num_reqs), 145'd2);

        // Backpressure: response held 5+ cycles while next request waits
        rdy_hold = 1'b0;
        send(3'd0, 8'h11, 32'h0000_1000, 128'd0);
        fork
            begin
                int w = 0;
                while (!bus.memresp_val && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) @(posedge clk);
                rdy_hold = 1'b1;
            end
            send(3'd0, 8'h12, 32'h0000_1000, 128'd0);
        join
        drain();

        // Address wrap onto line 1
        send(3'd1, 8'h21, 32'h0000_0010, {16{8'hAA}});
        send(3'd0, 8'h22, 32'h0000_1010, 128'd0);

        // Illegal type leaves storage untouched
        send(3'd5, 8'h7F, 32'h0000_0010, {16{8'h33}});
        send(3'd0, 8'h23, 32'h0000_0010, 128'd0);
        drain();

        // Reset during WAIT drops the response but keeps the committed write
        send(3'd1, 8'h31, 32'h0000_0020, {16{8'h55}});
        reset = 1'b1;
        sb.delete();
        n_acc   = n_resp;
        exp_num = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_resp_val", 145'(bus.memresp_val), 145'd0);
        chk("midrst_num_reqs", 145'(num_reqs), 145'd0);
        chk("midrst_req_rdy", 145'(bus.memreq_rdy), 145'd1);
        send(3'd0, 8'h32, 32'h0000_0020, 128'd0);
        drain();

        // Initialise every line, then random traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < NL; i++) begin
            a = $urandom;
            a[11:4] = 8'(i);
            d = {$urandom, $urandom, $urandom, $urandom};
            send(3'd2, 8'($urandom), a, d);
        end
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            d = {$urandom, $urandom, $urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r < 4)       tsel = 0;
            else if (r < 6)  tsel = 1;
            else if (r < 7)  tsel = 2;
            else             tsel = 3 + $urandom_range(0, 4);
            send(3'(tsel), 8'($urandom), a, d);
        end
        drain();
        chk("num_reqs_final", 145'(num_reqs), 145'(exp_num));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
